int_ctrl_nest: RTL and testbench

- Multi-source, nestable interrupt context controller; next generation of the single-level PC/flag save block.
- Arbitrates N_SRC maskable request lines by fixed priority.
- Pushes {PC, C, Z, source id} onto a DEPTH-entry context stack on acceptance and pops it on RETI.
- Sits beside the program counter/state sequencer, which consumes int_ack and int_vector and restores the context from the int_return_* outputs.

---
 rtl/int_ctrl_nest.sv | 147 ++++++++++++++
 tb/tb_int_ctrl_nest.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl_nest.sv
// Nestable fixed-priority interrupt controller with a DEPTH-entry {PC, C, Z, id} context stack.
// Optional sticky error flags compiled in with macro INT_NEST_ERR_EN.
module int_ctrl_nest #(
  parameter int D_WIDTH = 12,
  parameter int N_SRC   = 4,
  parameter int DEPTH   = 4,
  localparam int VW     = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int DW     = $clog2(DEPTH + 1),
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] int_current_pc,
  input  logic               int_cc_c,
  input  logic               int_cc_z,
  input  logic               int_en,
  input  logic [N_SRC-1:0]   int_req,
  input  logic [N_SRC-1:0]   int_mask,
  input  logic               reti_signal,
  output logic               int_ack,
  output logic [VW-1:0]      int_vector,
  output logic [D_WIDTH-1:0] int_return_pc,
  output logic               int_c,
  output logic               int_z,
  output logic               int_active,
  output logic [DW-1:0]      int_depth,
  output logic [1:0]         int_err
);

  logic [D_WIDTH-1:0] r_pc_stk [DEPTH];
  logic               r_c_stk  [DEPTH];
  logic               r_z_stk  [DEPTH];
  logic [VW-1:0]      r_id_stk [DEPTH];

  logic [DW-1:0]      r_depth;
  logic               r_ack;
  logic [VW-1:0]      r_vec;
  logic [D_WIDTH-1:0] r_ret_pc;
  logic               r_c;
  logic               r_z;
  logic [VW-1:0]      r_top_id;

  logic [N_SRC-1:0]   w_pend;
  logic [VW-1:0]      w_sel;
  logic               w_empty;
  logic               w_full;
  logic               w_base;
  logic               w_accept;
  logic               w_pop;
  logic [AW-1:0]      w_push_idx;
  logic [AW-1:0]      w_prev_idx;

  assign w_pend = int_req & int_mask;

  // Lowest set index wins: scan from the bottom of the priority order upward.
  always_comb begin
    w_sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_pend[i]) w_sel = VW'(i);
    end
  end

  assign w_empty    = (r_depth == '0);
  assign w_full     = (r_depth == DW'(DEPTH));
  assign w_base     = int_en && (|w_pend) && !r_ack && !reti_signal;
  assign w_accept   = w_base && !w_full && (w_empty || (w_sel < r_top_id));
  assign w_pop      = reti_signal && !w_empty;
  assign w_push_idx = AW'(r_depth);
  assign w_prev_idx = AW'(r_depth - DW'(2));

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pc_stk[w_push_idx] <= int_current_pc;
      r_c_stk[w_push_idx]  <= int_cc_c;
      r_z_stk[w_push_idx]  <= int_cc_z;
      r_id_stk[w_push_idx] <= w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth  <= '0;
      r_ack    <= 1'b0;
      r_vec    <= '0;
      r_ret_pc <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_top_id <= '0;
    end else begin
      r_ack <= w_accept;
      if (w_pop) begin
        r_depth <= r_depth - DW'(1);
        // After the pop the visible top is the entry below, or zeros when the stack drains.
        if (r_depth >= DW'(2)) begin
          r_ret_pc <= r_pc_stk[w_prev_idx];
          r_c      <= r_c_stk[w_prev_idx];
          r_z      <= r_z_stk[w_prev_idx];
          r_top_id <= r_id_stk[w_prev_idx];
        end else begin
          r_ret_pc <= '0;
          r_c      <= 1'b0;
          r_z      <= 1'b0;
          r_top_id <= '0;
        end
      end else if (w_accept) begin
        r_depth  <= r_depth + DW'(1);
        r_vec    <= w_sel;
        r_ret_pc <= int_current_pc;
        r_c      <= int_cc_c;
        r_z      <= int_cc_z;
        r_top_id <= w_sel;
      end
    end
  end

  assign int_ack       = r_ack;
  assign int_vector    = r_vec;
  assign int_return_pc = r_ret_pc;
  assign int_c         = r_c;
  assign int_z         = r_z;
  assign int_active    = !w_empty;
  assign int_depth     = r_depth;

`ifdef INT_NEST_ERR_EN
  logic       w_ovf;
  logic       w_udf;
  logic [1:0] r_err;

  // Overflow flags any live request blocked by a full stack, regardless of its priority.
  assign w_ovf = w_base && w_full;
  assign w_udf = reti_signal && w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 2'b00;
    end else begin
      if (w_ovf) r_err[0] <= 1'b1;
      if (w_udf) r_err[1] <= 1'b1;
    end
  end

  assign int_err = r_err;
`else
  assign int_err = 2'b00;
`endif

endmodule

// File: tb/tb_int_ctrl_nest.sv
// Directed bench for int_ctrl_nest: accepted contexts are queued as they are driven and checked on int_ack.
module tb_int_ctrl_nest;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] int_current_pc;
  logic        int_cc_c;
  logic        int_cc_z;
  logic        int_en;
  logic [3:0]  int_req;
  logic [3:0]  int_mask;
  logic        reti_signal;
  logic        int_ack;
  logic [1:0]  int_vector;
  logic [11:0] int_return_pc;
  logic        int_c;
  logic        int_z;
  logic        int_active;
  logic [2:0]  int_depth;
  logic [1:0]  int_err;

  int n_vec = 0;
  int n_err = 0;

`ifdef INT_NEST_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  vec;
    logic [11:0] pc;
    logic        c;
    logic        z;
  } ctx_t;

  ctx_t sb[$];

  int_ctrl_nest dut (
    .clk            (clk),
    .reset          (reset),
    .int_current_pc (int_current_pc),
    .int_cc_c       (int_cc_c),
    .int_cc_z       (int_cc_z),
    .int_en         (int_en),
    .int_req        (int_req),
    .int_mask       (int_mask),
    .reti_signal    (reti_signal),
    .int_ack        (int_ack),
    .int_vector     (int_vector),
    .int_return_pc  (int_return_pc),
    .int_c          (int_c),
    .int_z          (int_z),
    .int_active     (int_active),
    .int_depth      (int_depth),
    .int_err        (int_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ack(input logic [1:0] vec);
    ctx_t e;
    e.vec = vec;
    e.pc  = int_current_pc;
    e.c   = int_cc_c;
    e.z   = int_cc_z;
    sb.push_back(e);
  endtask

  // One clock; outputs sampled 1 time unit after the edge. An ack is expected exactly when a context is queued.
  task automatic step();
    ctx_t e;
    @(posedge clk);
    #1;
    chk("ack", 32'(int_ack), 32'(sb.size() != 0));
    if (int_ack === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      chk("ack_vector", 32'(int_vector), 32'(e.vec));
      chk("ack_pc", 32'(int_return_pc), 32'(e.pc));
      chk("ack_c", 32'(int_c), 32'(e.c));
      chk("ack_z", 32'(int_z), 32'(e.z));
    end
  endtask

  task automatic reti();
    reti_signal = 1'b1;
    step();
    reti_signal = 1'b0;
  endtask

  task automatic chk_top(input string tag, input logic [2:0] d, input logic [11:0] pc,
                         input logic c, input logic z);
    chk({tag, "_depth"}, 32'(int_depth), 32'(d));
    chk({tag, "_active"}, 32'(int_active), 32'(d != 3'd0));
    chk({tag, "_pc"}, 32'(int_return_pc), 32'(pc));
    chk({tag, "_c"}, 32'(int_c), 32'(c));
    chk({tag, "_z"}, 32'(int_z), 32'(z));
  endtask

  initial begin
    reset = 1'b1; int_en = 1'b0; int_mask = 4'hF; int_req = 4'h0; reti_signal = 1'b0;
    int_current_pc = 12'h000; int_cc_c = 1'b0; int_cc_z = 1'b0;
    step(); step();
    chk_top("rst", 3'd0, 12'h000, 1'b0, 1'b0);
    chk("rst_vector", 32'(int_vector), 0);
    chk("rst_err", 32'(int_err), 0);
    reset = 1'b0;

    // Single acceptance
    int_en = 1'b1; int_req = 4'b0100; int_current_pc = 12'h123; int_cc_c = 1'b1; int_cc_z = 1'b0;
    expect_ack(2'd2);
    step();
    chk_top("first", 3'd1, 12'h123, 1'b1, 1'b0);
    int_req = 4'h0;
    step();

    // Nesting by a higher priority source, then unwind
    int_req = 4'b0001; int_current_pc = 12'h200; int_cc_c = 1'b0; int_cc_z = 1'b1;
    expect_ack(2'd0);
    step();
    chk_top("nest", 3'd2, 12'h200, 1'b0, 1'b1);
    int_req = 4'h0;
    step();
    reti();
    chk_top("pop1", 3'd1, 12'h123, 1'b1, 1'b0);
    reti();
    chk_top("pop2", 3'd0, 12'h000, 1'b0, 1'b0);

    // Lower priority blocked while source 1 active
    int_req = 4'b0010; int_current_pc = 12'h310; int_cc_c = 1'b0; int_cc_z = 1'b0;
    expect_ack(2'd1);
    step();
    int_req = 4'b1010;
    for (int i = 0; i < 5; i++) step();
    chk("blocked_depth", 32'(int_depth), 1);
    int_req = 4'b1000; int_current_pc = 12'h3F0; int_cc_c = 1'b1; int_cc_z = 1'b1;
    reti();
    chk("unblock_pop_depth", 32'(int_depth), 0);
    expect_ack(2'd3);
    step();
    chk_top("unblocked", 3'd1, 12'h3F0, 1'b1, 1'b1);
    int_req = 4'h0;
    reti();
    chk("unblock_drain", 32'(int_depth), 0);

    // Fill to DEPTH, then hold a request against the full stack
    for (int s = 3; s >= 0; s--) begin
      int_req = 4'(1 << s);
      int_current_pc = 12'h400 + 12'(s);
      int_cc_c = s[0]; int_cc_z = s[1];
      expect_ack(2'(s));
      step();
      chk("fill_depth", 32'(int_depth), 32'(4 - s));
      step();
    end
    for (int i = 0; i < 4; i++) step();
    chk("full_depth", 32'(int_depth), 4);
    chk("ovf_err", 32'(int_err), ERR_ON ? 32'h1 : 32'h0);
    int_req = 4'h0;
    reti(); chk_top("drain1", 3'd3, 12'h401, 1'b1, 1'b0);
    reti(); chk_top("drain2", 3'd2, 12'h402, 1'b0, 1'b1);
    reti(); chk_top("drain3", 3'd1, 12'h403, 1'b1, 1'b1);
    reti(); chk_top("drain4", 3'd0, 12'h000, 1'b0, 1'b0);
    reti();
    chk("udf_depth", 32'(int_depth), 0);
    chk("udf_err", 32'(int_err), ERR_ON ? 32'h3 : 32'h0);

    // reti and a qualifying request in the same cycle
    int_req = 4'b0100; int_current_pc = 12'h500; int_cc_c = 1'b0; int_cc_z = 1'b1;
    expect_ack(2'd2);
    step();
    int_req = 4'h0;
    step();
    int_req = 4'b0001; int_current_pc = 12'h510; int_cc_c = 1'b1; int_cc_z = 1'b0;
    reti();
    chk("simul_depth", 32'(int_depth), 0);
    expect_ack(2'd0);
    step();
    chk_top("simul_repush", 3'd1, 12'h510, 1'b1, 1'b0);
    int_req = 4'h0;
    reti();

    // Reset while nested three deep
    for (int s = 3; s >= 1; s--) begin
      int_req = 4'(1 << s);
      int_current_pc = 12'h600 + 12'(s);
      int_cc_c = 1'b1; int_cc_z = 1'b1;
      expect_ack(2'(s));
      step();
      step();
    end
    chk("pre_rst_depth", 32'(int_depth), 3);
    int_req = 4'h0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_top("midrst", 3'd0, 12'h000, 1'b0, 1'b0);
    chk("midrst_vector", 32'(int_vector), 0);
    chk("midrst_err", 32'(int_err), 0);

    // Masked and globally disabled requests are never taken
    int_mask = 4'h0; int_req = 4'hF;
    for (int i = 0; i < 5; i++) step();
    chk("masked_depth", 32'(int_depth), 0);
    int_mask = 4'hF; int_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("disabled_depth", 32'(int_depth), 0);
    int_req = 4'h0;
    chk("sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
